// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of each complete frame of an
// asynchronous PWM waveform, in clk cycles. Results are double-buffered and
// only change at a frame boundary so software always reads a coherent pair.
// Stuck-line detection reports a waveform with no rising edge for TIMEOUT cycles.
module pwm_capture #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_q,
    output logic [CNT_W-1:0] period_q,
    output logic             meas_valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   timeout_hit;

    logic [CNT_W-1:0] period_cnt_q;
    logic [CNT_W-1:0] period_cnt_nxt;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] high_cnt_nxt;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0] idle_cnt_nxt;

    logic [CNT_W-1:0] high_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             meas_valid_nxt;
    logic             stuck_hi_nxt;
    logic             stuck_lo_nxt;

    // Synchronized line level and its one-cycle-delayed copy for edge detection
    assign s           = sync_q[SYNC_STAGES-1];
    assign rise        = s & ~s_d;
    assign timeout_hit = (idle_cnt_q == TIMEOUT_M1);

    // Input synchronizer chain plus the edge-detect flop
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d    <= s;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state, counter and result logic; rise takes priority over timeout
    always_comb begin
        state_nxt      = state_q;
        period_cnt_nxt = period_cnt_q;
        high_cnt_nxt   = high_cnt_q;
        idle_cnt_nxt   = idle_cnt_q;
        high_nxt       = high_q;
        period_nxt     = period_q;
        meas_valid_nxt = 1'b0;
        stuck_hi_nxt   = stuck_hi;
        stuck_lo_nxt   = stuck_lo;

        if (!en) begin
            state_nxt      = ST_IDLE;
            period_cnt_nxt = CNT_ZERO;
            high_cnt_nxt   = CNT_ZERO;
            idle_cnt_nxt   = CNT_ZERO;
            stuck_hi_nxt   = 1'b0;
            stuck_lo_nxt   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    period_cnt_nxt = CNT_ZERO;
                    high_cnt_nxt   = CNT_ZERO;
                    idle_cnt_nxt   = CNT_ZERO;
                    state_nxt      = ST_ARM;
                end

                ST_ARM: begin
                    if (rise) begin
                        // First edge of a frame: start counting, nothing to report yet
                        period_cnt_nxt = CNT_ONE;
                        high_cnt_nxt   = CNT_ONE;
                        idle_cnt_nxt   = CNT_ZERO;
                        stuck_hi_nxt   = 1'b0;
                        stuck_lo_nxt   = 1'b0;
                        state_nxt      = ST_MEAS;
                    end else if (timeout_hit) begin
                        stuck_hi_nxt   = s;
                        stuck_lo_nxt   = ~s;
                        idle_cnt_nxt   = TIMEOUT_MAX;
                        period_cnt_nxt = CNT_ZERO;
                        high_cnt_nxt   = CNT_ZERO;
                    end else if (idle_cnt_q != TIMEOUT_MAX) begin
                        idle_cnt_nxt = idle_cnt_q + CNT_ONE;
                    end
                end

                ST_MEAS: begin
                    if (rise) begin
                        // Frame complete: publish the pair and restart counting
                        high_nxt       = high_cnt_q;
                        period_nxt     = period_cnt_q;
                        meas_valid_nxt = 1'b1;
                        period_cnt_nxt = CNT_ONE;
                        high_cnt_nxt   = CNT_ONE;
                        idle_cnt_nxt   = CNT_ZERO;
                        stuck_hi_nxt   = 1'b0;
                        stuck_lo_nxt   = 1'b0;
                    end else if (timeout_hit) begin
                        // Line stuck: drop the partial frame, keep the old result
                        stuck_hi_nxt   = s;
                        stuck_lo_nxt   = ~s;
                        idle_cnt_nxt   = TIMEOUT_MAX;
                        period_cnt_nxt = CNT_ZERO;
                        high_cnt_nxt   = CNT_ZERO;
                        state_nxt      = ST_ARM;
                    end else begin
                        period_cnt_nxt = period_cnt_q + CNT_ONE;
                        high_cnt_nxt   = high_cnt_q + CNT_W'(s);
                        idle_cnt_nxt   = idle_cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_nxt      = ST_IDLE;
                    period_cnt_nxt = CNT_ZERO;
                    high_cnt_nxt   = CNT_ZERO;
                    idle_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Counters, results and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_q <= CNT_ZERO;
            high_cnt_q   <= CNT_ZERO;
            idle_cnt_q   <= CNT_ZERO;
            high_q       <= CNT_ZERO;
            period_q     <= CNT_ZERO;
            meas_valid   <= 1'b0;
            stuck_hi     <= 1'b0;
            stuck_lo     <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_nxt;
            high_cnt_q   <= high_cnt_nxt;
            idle_cnt_q   <= idle_cnt_nxt;
            high_q       <= high_nxt;
            period_q     <= period_nxt;
            meas_valid   <= meas_valid_nxt;
            stuck_hi     <= stuck_hi_nxt;
            stuck_lo     <= stuck_lo_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture. Two instances share the
// stimulus: one with the default timeout for long-frame measurements and one
// with TIMEOUT=100 for stuck-line and timeout-boundary cases.
module tb_pwm_capture;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] period_q;
    logic             meas_valid;
    logic             stuck_hi;
    logic             stuck_lo;
    logic [CNT_W-1:0] high_q2;
    logic [CNT_W-1:0] period_q2;
    logic             meas_valid2;
    logic             stuck_hi2;
    logic             stuck_lo2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int mv_cnt       = 0;
    int mv2_cnt      = 0;
    int last_mv_cyc  = 0;
    int last_mv2_cyc = 0;
    int last_hi      = 0;
    int last_per     = 0;
    int last_hi2     = 0;
    int last_per2    = 0;

    bit gen_on         = 1'b0;
    int gen_period     = 256;
    int gen_high       = 20;
    int gen_high_nxt   = 20;
    int phase          = 0;
    int rise_cnt       = 0;
    int rise_drive_cyc = 0;

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(65535)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_q     (high_q),
        .period_q   (period_q),
        .meas_valid (meas_valid),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(100)) dut_to (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_q     (high_q2),
        .period_q   (period_q2),
        .meas_valid (meas_valid2),
        .stuck_hi   (stuck_hi2),
        .stuck_lo   (stuck_lo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hang guard
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs just after the edge, then drive the next PWM sample
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (meas_valid) begin
            mv_cnt++;
            last_mv_cyc = cyc;
            last_hi     = int'(high_q);
            last_per    = int'(period_q);
        end
        if (meas_valid2) begin
            mv2_cnt++;
            last_mv2_cyc = cyc;
            last_hi2     = int'(high_q2);
            last_per2    = int'(period_q2);
        end
        if (gen_on) begin
            if (phase == 0) begin
                gen_high       = gen_high_nxt;
                rise_cnt++;
                rise_drive_cyc = cyc;
            end
            pwm_in = (phase < gen_high);
            phase  = (phase + 1 == gen_period) ? 0 : phase + 1;
        end
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_mv(input int bound);
        int start;
        int n;
        start = mv_cnt;
        n = 0;
        while (mv_cnt == start && n < bound) begin
            tick();
            n++;
        end
        check("wait_meas_valid", 32'(mv_cnt != start), 32'd1);
    endtask

    task automatic wait_mv2(input int bound);
        int start;
        int n;
        start = mv2_cnt;
        n = 0;
        while (mv2_cnt == start && n < bound) begin
            tick();
            n++;
        end
        check("wait_meas_valid_to", 32'(mv2_cnt != start), 32'd1);
    endtask

    task automatic wait_rise(input int bound);
        int start;
        int n;
        start = rise_cnt;
        n = 0;
        while (rise_cnt == start && n < bound) begin
            tick();
            n++;
        end
        check("wait_rise_drive", 32'(rise_cnt != start), 32'd1);
    endtask

    initial begin
        int prev;
        int snap;
        int r;

        // Reset state
        rst = 1'b1;
        en = 1'b0;
        pwm_in = 1'b0;
        repeat (4) tick();
        check("rst_high_q", 32'(high_q), 32'd0);
        check("rst_period_q", 32'(period_q), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_stuck_hi", 32'(stuck_hi), 32'd0);
        check("rst_stuck_lo", 32'(stuck_lo), 32'd0);

        // Steady PWM 256/20: first result at the second rising edge
        rst = 1'b0;
        en = 1'b1;
        repeat (3) tick();
        gen_period = 256;
        gen_high = 20;
        gen_high_nxt = 20;
        phase = 0;
        rise_cnt = 0;
        gen_on = 1'b1;
        wait_mv(700);
        check("first_meas_rise_count", 32'(rise_cnt), 32'd2);
        check("first_high", 32'(last_hi), 32'd20);
        check("first_period", 32'(last_per), 32'd256);
        check("latency", 32'(last_mv_cyc - rise_drive_cyc), 32'd3);
        tick();
        check("meas_valid_one_cycle", 32'(meas_valid), 32'd0);
        prev = last_mv_cyc;
        wait_mv(300);
        check("steady_spacing", 32'(last_mv_cyc - prev), 32'd256);
        check("steady_high", 32'(last_hi), 32'd20);
        check("steady_period", 32'(last_per), 32'd256);

        // Duty change at the generator frame boundary: 20 then 5
        gen_high_nxt = 5;
        wait_mv(300);
        check("duty_old_high", 32'(last_hi), 32'd20);
        check("duty_old_period", 32'(last_per), 32'd256);
        wait_mv(300);
        check("duty_new_high", 32'(last_hi), 32'd5);
        check("duty_new_period", 32'(last_per), 32'd256);
        gen_high_nxt = 20;
        wait_mv(300);
        wait_mv(300);
        check("duty_restored_high", 32'(last_hi), 32'd20);

        // Reset pulse mid-frame: outputs clear, two fresh rises needed
        tick_until(rise_drive_cyc + 100);
        rst = 1'b1;
        tick();
        check("midrst_high_q", 32'(high_q), 32'd0);
        check("midrst_period_q", 32'(period_q), 32'd0);
        check("midrst_meas_valid", 32'(meas_valid), 32'd0);
        check("midrst_stuck_hi", 32'(stuck_hi), 32'd0);
        check("midrst_stuck_lo", 32'(stuck_lo), 32'd0);
        rst = 1'b0;
        snap = mv_cnt;
        rise_cnt = 0;
        repeat (200) tick();
        check("midrst_first_rise_seen", 32'(rise_cnt), 32'd1);
        check("midrst_no_meas_on_arm", 32'(mv_cnt - snap), 32'd0);
        check("midrst_high_held_zero", 32'(high_q), 32'd0);
        wait_mv(400);
        check("midrst_meas_rise_count", 32'(rise_cnt), 32'd2);
        check("midrst_high", 32'(last_hi), 32'd20);
        check("midrst_period", 32'(last_per), 32'd256);

        // en low for 50 cycles mid-frame
        repeat (10) tick();
        en = 1'b0;
        snap = mv_cnt;
        repeat (50) tick();
        check("en_low_no_meas", 32'(mv_cnt - snap), 32'd0);
        check("en_low_high_held", 32'(high_q), 32'd20);
        check("en_low_period_held", 32'(period_q), 32'd256);
        check("en_low_stuck_lo", 32'(stuck_lo), 32'd0);
        en = 1'b1;
        rise_cnt = 0;
        wait_mv(700);
        check("en_back_rise_count", 32'(rise_cnt), 32'd2);
        check("en_back_high", 32'(last_hi), 32'd20);
        check("en_back_period", 32'(last_per), 32'd256);

        // Stuck-line tests on the TIMEOUT=100 instance, 50/10 waveform
        gen_on = 1'b0;
        pwm_in = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        gen_period = 50;
        gen_high = 10;
        gen_high_nxt = 10;
        phase = 0;
        gen_on = 1'b1;
        wait_mv2(300);
        check("to_high", 32'(last_hi2), 32'd10);
        check("to_period", 32'(last_per2), 32'd50);

        // Line held high after a rise
        wait_rise(100);
        r = rise_drive_cyc;
        gen_on = 1'b0;
        tick_until(r + 102);
        check("stuck_hi_not_early", 32'(stuck_hi2), 32'd0);
        tick();
        check("stuck_hi_set", 32'(stuck_hi2), 32'd1);
        check("stuck_hi_lo_clear", 32'(stuck_lo2), 32'd0);
        snap = mv2_cnt;
        repeat (20) tick();
        check("stuck_hi_no_meas", 32'(mv2_cnt - snap), 32'd0);
        check("stuck_hi_high_held", 32'(high_q2), 32'd10);
        check("stuck_hi_period_held", 32'(period_q2), 32'd50);
        check("stuck_hi_stays", 32'(stuck_hi2), 32'd1);

        // Line released: clearing rise produces no measurement, next frame does
        phase = 10;
        gen_on = 1'b1;
        snap = mv2_cnt;
        wait_rise(100);
        r = rise_drive_cyc;
        repeat (2) tick();
        check("stuck_hi_before_clear", 32'(stuck_hi2), 32'd1);
        tick();
        check("stuck_hi_cleared", 32'(stuck_hi2), 32'd0);
        check("clear_rise_no_meas", 32'(mv2_cnt - snap), 32'd0);
        wait_mv2(100);
        check("recover_meas_cycle", 32'(last_mv2_cyc - r), 32'd53);
        check("recover_high", 32'(last_hi2), 32'd10);
        check("recover_period", 32'(last_per2), 32'd50);

        // Line held low after a full high pulse
        wait_rise(100);
        r = rise_drive_cyc;
        repeat (9) tick();
        gen_on = 1'b0;
        pwm_in = 1'b0;
        tick_until(r + 102);
        check("stuck_lo_not_early", 32'(stuck_lo2), 32'd0);
        tick();
        check("stuck_lo_set", 32'(stuck_lo2), 32'd1);
        check("stuck_lo_hi_clear", 32'(stuck_hi2), 32'd0);
        check("stuck_lo_high_held", 32'(high_q2), 32'd10);
        check("stuck_lo_period_held", 32'(period_q2), 32'd50);

        // Period exactly TIMEOUT: rise coincides with timeout and wins
        gen_period = 100;
        gen_high = 30;
        gen_high_nxt = 30;
        phase = 0;
        gen_on = 1'b1;
        wait_rise(100);
        repeat (3) tick();
        check("boundary_stuck_lo_cleared", 32'(stuck_lo2), 32'd0);
        wait_mv2(200);
        check("boundary_high_1", 32'(last_hi2), 32'd30);
        check("boundary_period_1", 32'(last_per2), 32'd100);
        wait_mv2(200);
        check("boundary_high_2", 32'(last_hi2), 32'd30);
        check("boundary_period_2", 32'(last_per2), 32'd100);
        check("boundary_no_stuck_lo", 32'(stuck_lo2), 32'd0);
        check("boundary_no_stuck_hi", 32'(stuck_hi2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
